// File: rtl/lfsr_gen_if.sv
// Control and status bundle for lfsr_gen. The master drives the controls and the slave
// (the generator) returns its state, pulses and period measurement.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = WIDTH
);
  logic             galois;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic [CNT_W-1:0] nsteps;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             lockup;
  logic             wrap;
  logic [CNT_W-1:0] period;

  modport master (
    output galois, en, load, load_val, start, nsteps,
    input  out, busy, done, lockup, wrap, period
  );

  modport slave (
    input  galois, en, load, load_val, start, nsteps,
    output out, busy, done, lockup, wrap, period
  );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci/Galois LFSR with seed load, free-run and counted bursts, zero-lockup guard
// and period measurement against the most recent start value.
module lfsr_gen #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED  = 16'h0001,
  parameter int unsigned       CNT_W = WIDTH
) (
  input logic        clk,
  input logic        nReset,
  lfsr_gen_if.slave  bus
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] start_val_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] remaining_q;
  logic             busy_q;
  logic             done_q;
  logic             lockup_q;
  logic             wrap_q;

  logic [WIDTH-1:0] fib_nxt;
  logic [WIDTH-1:0] gal_nxt;
  logic [WIDTH-1:0] step_raw;
  logic [WIDTH-1:0] step_val;
  logic             step_zero;
  logic [CNT_W-1:0] count_inc;
  logic             do_step;

  always_comb begin
    fib_nxt   = {out_q[WIDTH-2:0], ^(out_q & TAPS)};
    // Galois mask carries the same polynomial as the Fibonacci tap set.
    gal_nxt   = {out_q[WIDTH-2:0], 1'b0} ^
                ({WIDTH{out_q[WIDTH-1]}} & {TAPS[WIDTH-2:0], 1'b1});
    step_raw  = bus.galois ? gal_nxt : fib_nxt;
    step_zero = (step_raw == '0);
    step_val  = step_zero ? SEED : step_raw;
    count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    do_step   = !bus.load && ((state_q == StRun) || bus.en);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= StIdle;
      out_q       <= SEED;
      start_val_q <= SEED;
      count_q     <= '0;
      period_q    <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lockup_q    <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
      if (bus.load) begin
        if (bus.load_val == '0) begin
          out_q       <= SEED;
          start_val_q <= SEED;
          lockup_q    <= 1'b1;
        end else begin
          out_q       <= bus.load_val;
          start_val_q <= bus.load_val;
        end
        count_q <= '0;
        busy_q  <= 1'b0;
        state_q <= StIdle;
      end else begin
        if (do_step) begin
          out_q    <= step_val;
          lockup_q <= step_zero;
          if (step_val == start_val_q) begin
            wrap_q   <= 1'b1;
            period_q <= count_inc;
            count_q  <= '0;
          end else begin
            count_q  <= count_inc;
          end
        end
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              if (bus.nsteps != '0) begin
                state_q     <= StRun;
                busy_q      <= 1'b1;
                remaining_q <= bus.nsteps;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          StRun: begin
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.out    = out_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.lockup = lockup_q;
  assign bus.wrap   = wrap_q;
  assign bus.period = period_q;

endmodule
